// File: rtl/fp_result_monitor.sv
// Scoreboard for float_add results: queues expected values, compares each result one cycle after it arrives.
// Optional ULP-tolerance compare is enabled by defining FPMON_TOL_EN.
module fp_result_monitor #(
  parameter int DEPTH_LOG2   = 3,
  parameter int TOL_ULP      = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        exp_valid,
  input  logic [31:0] exp_data,
  output logic        exp_ready,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        err,
  output logic        ovf,
  output logic        udf,
  output logic        halted,
  output logic [31:0] fail_res,
  output logic [31:0] fail_exp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef FPMON_TOL_EN
  localparam bit TOL_EN = 1'b1;
`else
  localparam bit TOL_EN = 1'b0;
`endif
  // A zero limit makes the magnitude compare equivalent to bit-identical.
  localparam logic [30:0] TOL_LIMIT = TOL_EN ? 31'(TOL_ULP) : 31'd0;

  typedef enum logic {RUN, HALT} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, empty, running;
  logic                  push, pop, push_drop, pop_drop;
  logic                  cmp_valid, cmp_match;
  logic [31:0]           cmp_res, cmp_exp;

  function automatic logic values_match(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_zero, b_zero;
    logic [30:0] diff;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    diff   = (a[30:0] >= b[30:0]) ? a[30:0] - b[30:0] : b[30:0] - a[30:0];
    if (a_nan || b_nan)   return a_nan && b_nan;
    if (a_zero && b_zero) return 1'b1;
    if (a_zero || b_zero) return 1'b0;
    if (a[31] != b[31])   return 1'b0;
    return diff <= TOL_LIMIT;
  endfunction

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign running   = (state == RUN);
  assign exp_ready = running && !full;
  assign halted    = (state == HALT);

  // A pop in the same cycle never frees room for a push, and a push never feeds a pop.
  assign push      = running && exp_valid && !full;
  assign push_drop = running && exp_valid && full;
  assign pop       = running && res_valid && !empty;
  assign pop_drop  = running && res_valid && empty;

  assign cmp_match = values_match(cmp_res, cmp_exp);

  // NOTE: queue storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmp_valid <= 1'b0;
      cmp_res   <= 32'h0;
      cmp_exp   <= 32'h0;
      pass_cnt  <= 16'h0;
      fail_cnt  <= 16'h0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      fail_res  <= 32'h0;
      fail_exp  <= 32'h0;
    end else if (clear) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmp_valid <= 1'b0;
      cmp_res   <= 32'h0;
      cmp_exp   <= 32'h0;
      pass_cnt  <= 16'h0;
      fail_cnt  <= 16'h0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      fail_res  <= 32'h0;
      fail_exp  <= 32'h0;
    end else if (running) begin
      if (cmp_valid) begin
        if (cmp_match) begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end else begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
          if (fail_cnt == 16'h0) begin
            fail_res <= cmp_res;
            fail_exp <= cmp_exp;
          end
          err <= 1'b1;
          if (STOP_ON_FAIL != 0) state <= HALT;
        end
      end

      cmp_valid <= pop;
      if (pop) begin
        cmp_res <= res_data;
        cmp_exp <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (push_drop) begin
        ovf <= 1'b1;
        err <= 1'b1;
      end
      if (pop_drop) begin
        udf <= 1'b1;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_result_monitor.sv
// Self-checking bench for fp_result_monitor: vector table, directed corner sequences and a
// randomized run against a queue-based reference model. A second instance covers STOP_ON_FAIL=1.
module tb_fp_result_monitor;

  localparam int DL2   = 3;
  localparam int DEPTH = 8;
  localparam int TOL   = 1;
`ifdef FPMON_TOL_EN
  localparam bit TOL_ON = 1'b1;
`else
  localparam bit TOL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, exp_valid, res_valid;
  logic [31:0] exp_data, res_data;
  logic        exp_ready, err, ovf, udf, halted;
  logic [15:0] pass_cnt, fail_cnt;
  logic [31:0] fail_res, fail_exp;

  logic        h_clear, h_exp_valid, h_res_valid;
  logic [31:0] h_exp_data, h_res_data;
  logic        h_exp_ready, h_err, h_ovf, h_udf, h_halted;
  logic [15:0] h_pass_cnt, h_fail_cnt;
  logic [31:0] h_fail_res, h_fail_exp;

  fp_result_monitor #(.DEPTH_LOG2(DL2), .TOL_ULP(TOL), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .res_valid(res_valid), .res_data(res_data),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err(err), .ovf(ovf), .udf(udf), .halted(halted),
    .fail_res(fail_res), .fail_exp(fail_exp)
  );

  fp_result_monitor #(.DEPTH_LOG2(DL2), .TOL_ULP(TOL), .STOP_ON_FAIL(1)) dut_h (
    .clk(clk), .rst(rst), .clear(h_clear),
    .exp_valid(h_exp_valid), .exp_data(h_exp_data), .exp_ready(h_exp_ready),
    .res_valid(h_res_valid), .res_data(h_res_data),
    .pass_cnt(h_pass_cnt), .fail_cnt(h_fail_cnt),
    .err(h_err), .ovf(h_ovf), .udf(h_udf), .halted(h_halted),
    .fail_res(h_fail_res), .fail_exp(h_fail_exp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference model: an unbounded queue trimmed to DEPTH, plus one pending compare.
  logic [31:0] m_q [$];
  int          m_pass, m_fail;
  bit          m_err, m_ovf, m_udf;
  logic [31:0] m_fres, m_fexp;
  bit          m_pend, m_pend_ok;
  logic [31:0] m_pend_res, m_pend_exp;

  function automatic bit ref_match(input logic [31:0] r, input logic [31:0] e);
    bit     r_nan, e_nan;
    longint d;
    r_nan = r[30:0] > 31'h7F80_0000;
    e_nan = e[30:0] > 31'h7F80_0000;
    if (r_nan || e_nan) return r_nan && e_nan;
    if (r[30:0] == 31'd0 && e[30:0] == 31'd0) return 1'b1;
    if (r == e) return 1'b1;
    if (TOL_ON && r[31] == e[31] && r[30:0] != 31'd0 && e[30:0] != 31'd0) begin
      d = longint'(r[30:0]) - longint'(e[30:0]);
      if (d < 0) d = -d;
      return d <= TOL;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0;
    m_err = 0; m_ovf = 0; m_udf = 0;
    m_fres = 32'h0; m_fexp = 32'h0;
    m_pend = 0;
  endtask

  task automatic model_edge(input bit ev, input logic [31:0] ed, input bit rv,
                            input logic [31:0] rd, input bit clr);
    bit was_full, was_empty;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_pend) begin
      if (m_pend_ok) m_pass = (m_pass < 65535) ? m_pass + 1 : 65535;
      else begin
        if (m_fail == 0) begin
          m_fres = m_pend_res;
          m_fexp = m_pend_exp;
        end
        m_fail = (m_fail < 65535) ? m_fail + 1 : 65535;
        m_err  = 1;
      end
      m_pend = 0;
    end
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (rv) begin
      if (was_empty) begin
        m_udf = 1; m_err = 1;
      end else begin
        m_pend_exp = m_q.pop_front();
        m_pend_res = rd;
        m_pend_ok  = ref_match(rd, m_pend_exp);
        m_pend     = 1;
      end
    end
    if (ev) begin
      if (was_full) begin
        m_ovf = 1; m_err = 1;
      end else m_q.push_back(ed);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " exp_ready"}, exp_ready, m_q.size() < DEPTH);
    check({tag, " pass_cnt"}, pass_cnt, m_pass);
    check({tag, " fail_cnt"}, fail_cnt, m_fail);
    check({tag, " err"}, err, m_err);
    check({tag, " ovf"}, ovf, m_ovf);
    check({tag, " udf"}, udf, m_udf);
    check({tag, " halted"}, halted, 1'b0);
    check({tag, " fail_res"}, fail_res, m_fres);
    check({tag, " fail_exp"}, fail_exp, m_fexp);
  endtask

  task automatic step(input string tag, input bit ev, input logic [31:0] ed,
                      input bit rv, input logic [31:0] rd, input bit clr);
    exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd; clear = clr;
    @(posedge clk);
    model_edge(ev, ed, rv, rd, clr);
    #1;
    exp_valid = 0; res_valid = 0; clear = 0;
    check_all(tag);
  endtask

  task automatic hstep(input bit ev, input logic [31:0] ed, input bit rv,
                       input logic [31:0] rd, input bit clr);
    h_exp_valid = ev; h_exp_data = ed; h_res_valid = rv; h_res_data = rd; h_clear = clr;
    @(posedge clk);
    #1;
    h_exp_valid = 0; h_res_valid = 0; h_clear = 0;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h3F80_0000;
      1: return {r[31], 8'hFF, 1'b1, r[21:0]};
      2: return {r[31], 31'd0};
      3: return 32'h4000_0000;
      default: return r;
    endcase
  endfunction

  typedef struct {
    logic [31:0] e;
    logic [31:0] r;
    bit          ok;
  } vec_t;

  initial begin
    vec_t        vecs [$];
    int          exp_p, exp_f;
    logic [31:0] f, rd;
    bit          ev, rv;

    rst = 1'b1;
    clear = 0; exp_valid = 0; res_valid = 0; exp_data = 0; res_data = 0;
    h_clear = 0; h_exp_valid = 0; h_res_valid = 0; h_exp_data = 0; h_res_data = 0;
    model_reset();
    #12 rst = 1'b0;
    #1;
    check_all("reset");

    // Basic two-value sequence; the model checks the one-cycle compare latency.
    step("push1", 1, 32'h3FC0_0000, 0, 0, 0);
    step("push2", 1, 32'h4000_0000, 0, 0, 0);
    step("res1", 0, 0, 1, 32'h3FC0_0000, 0);
    check("basic pass after res1", pass_cnt, 16'd0);
    step("res2", 0, 0, 1, 32'h4000_0000, 0);
    check("basic pass after res2", pass_cnt, 16'd1);
    step("idle", 0, 0, 0, 0, 0);
    check("basic pass final", pass_cnt, 16'd2);
    check("basic err final", err, 1'b0);

    // Match-rule table.
    vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h8000_0000, 1'b1});
    vecs.push_back('{32'h7FC0_0000, 32'h7F80_0001, 1'b1});
    vecs.push_back('{32'hFFC0_0000, 32'h7FC0_1234, 1'b1});
    vecs.push_back('{32'h7FC0_0000, 32'h3F80_0000, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h7FC0_0000, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b1});
    vecs.push_back('{32'h3F80_0000, 32'hBF80_0000, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0001, TOL_ON});
    vecs.push_back('{32'h3F80_0001, 32'h3F80_0000, TOL_ON});
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0002, 1'b0});
    vecs.push_back('{32'h4120_0000, 32'h4120_0000, 1'b1});
    step("clr", 0, 0, 0, 0, 1);
    exp_p = 0; exp_f = 0;
    foreach (vecs[i]) begin
      step("vec push", 1, vecs[i].e, 0, 0, 0);
      step("vec res", 0, 0, 1, vecs[i].r, 0);
      step("vec idle", 0, 0, 0, 0, 0);
      if (vecs[i].ok) exp_p++; else exp_f++;
      check($sformatf("vec%0d pass_cnt", i), pass_cnt, exp_p);
      check($sformatf("vec%0d fail_cnt", i), fail_cnt, exp_f);
    end

    // Overflow: nine pushes into eight slots, then eight matching results.
    step("clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step("fill", 1, 32'h4000_0000 + i, 0, 0, 0);
      if (i == 7) check("ready after 8th push", exp_ready, 1'b0);
    end
    check("ovf after 9th push", ovf, 1'b1);
    check("err after 9th push", err, 1'b1);
    for (int i = 0; i < 8; i++) step("drain", 0, 0, 1, 32'h4000_0000 + i, 0);
    step("idle", 0, 0, 0, 0, 0);
    check("pass after drain", pass_cnt, 16'd8);

    // Underflow.
    step("clr", 0, 0, 0, 0, 1);
    step("udf", 0, 0, 1, 32'h3F80_0000, 0);
    step("idle", 0, 0, 0, 0, 0);
    check("udf set", udf, 1'b1);
    check("udf pass", pass_cnt, 16'd0);
    check("udf fail", fail_cnt, 16'd0);

    // Same-cycle push and pop on an empty queue: no bypass.
    step("clr", 0, 0, 0, 0, 1);
    step("nobypass", 1, 32'h3F80_0000, 1, 32'h3F80_0000, 0);
    step("nobypass res", 0, 0, 1, 32'h3F80_0000, 0);
    step("idle", 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    step("clr", 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      ev = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 50);
      rd = rand_val();
      if (m_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        f = m_q[0];
        case ($urandom_range(0, 4))
          0: rd = f + 32'd1;
          1: rd = f + 32'd2;
          2: rd = f - 32'd1;
          3: rd = {~f[31], f[30:0]};
          default: rd = f;
        endcase
      end
      step("rand", ev, rand_val(), rv, rd, 0);
    end

    // Asynchronous reset mid-cycle with four entries queued and a compare in flight.
    step("clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("q4", 1, 32'h3F80_0000, 0, 0, 0);
    step("inflight", 0, 0, 1, 32'h3F80_0000, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async rst");
    #2 rst = 1'b0;
    step("post rst", 0, 0, 0, 0, 0);
    step("post rst", 0, 0, 0, 0, 0);
    check("post rst pass", pass_cnt, 16'd0);
    step("post rst udf", 0, 0, 1, 32'h3F80_0000, 0);
    step("idle", 0, 0, 0, 0, 0);
    check("queue discarded by rst", udf, 1'b1);

    // STOP_ON_FAIL instance.
    hstep(1, 32'h3F80_0000, 0, 0, 0);
    hstep(0, 0, 1, 32'h3F80_0002, 0);
    check("halt in flight", h_halted, 1'b0);
    check("halt fail in flight", h_fail_cnt, 16'd0);
    hstep(0, 0, 0, 0, 0);
    check("halt halted", h_halted, 1'b1);
    check("halt fail_cnt", h_fail_cnt, 16'd1);
    check("halt fail_res", h_fail_res, 32'h3F80_0002);
    check("halt fail_exp", h_fail_exp, 32'h3F80_0000);
    check("halt err", h_err, 1'b1);
    check("halt exp_ready", h_exp_ready, 1'b0);
    for (int i = 0; i < 3; i++) hstep(1, 32'h4000_0000, 1, 32'h4000_0000, 0);
    check("halt frozen pass", h_pass_cnt, 16'd0);
    check("halt frozen fail", h_fail_cnt, 16'd1);
    check("halt frozen udf", h_udf, 1'b0);
    check("halt frozen ovf", h_ovf, 1'b0);
    check("halt still halted", h_halted, 1'b1);
    hstep(0, 0, 0, 0, 1);
    check("clr halted", h_halted, 1'b0);
    check("clr exp_ready", h_exp_ready, 1'b1);
    check("clr fail_cnt", h_fail_cnt, 16'd0);
    check("clr err", h_err, 1'b0);
    check("clr fail_res", h_fail_res, 32'h0);
    check("clr fail_exp", h_fail_exp, 32'h0);
    hstep(1, 32'h3F80_0000, 0, 0, 0);
    hstep(0, 0, 1, 32'h3F80_0000, 0);
    hstep(0, 0, 0, 0, 0);
    check("run after clr pass", h_pass_cnt, 16'd1);
    check("run after clr udf", h_udf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
